// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module   : input_debouncer_if
//  Purpose  : Signal bundle between a raw-input producer and input_debouncer.
//             The master side drives the raw pin and the glitch-counter clear.
//             The slave side (the debouncer) returns the clean level, the
//             change strobe and the glitch count.
//  Revision : 1.0  initial release
// ============================================================================
interface input_debouncer_if #(
  parameter int GLITCH_W = 8
);
  logic                din;
  logic                glitch_clr;
  logic                dout;
  logic                chg;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output din,
    output glitch_clr,
    input  dout,
    input  chg,
    input  glitch_cnt
  );

  modport slave (
    input  din,
    input  glitch_clr,
    output dout,
    output chg,
    output glitch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : input_debouncer
//  Purpose  : Synchronizes a raw asynchronous input and accepts a new level
//             only after STABLE_CYCLES consecutive identical synchronized
//             samples. Provides a registered level, a one-cycle change strobe
//             and a saturating count of rejected excursions.
//  Revision : 1.0  initial release
// ============================================================================
module input_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 8,
  parameter logic RESET_LEVEL   = 1'b1,
  parameter int   GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input_debouncer_if.slave    bus
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = (RESET_LEVEL == 1'b1) ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   chg_q, chg_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  logic                   glitch_inc;
  logic                   s;

  // The FSM only ever looks at the last synchronizer stage.
  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw input into the synchronizer chain (stage 0 is nearest din).
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.din};
  end

  // Debounce FSM: a pending state counts samples of the new level; any
  // return to the old level before the count completes is a glitch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    chg_d      = 1'b0;
    glitch_inc = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_HI: begin
        if (s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            dout_d  = 1'b1;
            chg_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d    = STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PEND_LO: begin
        if (!s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            dout_d  = 1'b0;
            chg_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Glitch counter: clear has priority over an increment; saturates at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (bus.glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_inc && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  // State register; reset reloads the idle level everywhere, dropping any pending change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      dout_q   <= RESET_LEVEL;
      chg_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      chg_q    <= chg_d;
      glitch_q <= glitch_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.chg        = chg_q;
  assign bus.glitch_cnt = glitch_q;

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions a raw asynchronous input (push-button, external pin) into a clean, glitch-free level for the falling-edge detection stage directly downstream.
- Signal path: synchronizer chain → 4-state debounce FSM with stability counter → registered level output.
- Also provides a one-cycle change strobe and a saturating count of rejected glitches for debug.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range ≥2.
- STABLE_CYCLES, 8, consecutive identical synchronized samples needed to accept a new level; legal range ≥2.
- RESET_LEVEL, 1'b1, reset value of synchronizer flops and dout; idle-high matches active-low buttons.
- GLITCH_W, 8, width of glitch counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  raw asynchronous input; may bounce.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- dout  output  1  debounced level; feeds the falling-edge detector.
- chg  output  1  one-cycle pulse in the cycle dout takes a new value.
- glitch_cnt  output  GLITCH_W  saturating count of rejected transitions.

Behaviour:
- Reset (rst=1 at an edge) forces the following:
  - all sync flops = RESET_LEVEL; dout = RESET_LEVEL.
  - state = STABLE_HI if RESET_LEVEL=1, else STABLE_LO.
  - stability counter = 0; chg = 0; glitch_cnt = 0.
- Reset mid-pending discards the pending transition; no chg pulse, no glitch count.
- Synchronizer: din → sync[0] → … → sync[SYNC_STAGES-1]. Call the last stage s. The FSM observes s only, never din.
- Stability counter: width $clog2(STABLE_CYCLES+1).
- FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
- STABLE_LO:
  - s=1 → PEND_HI, cnt=1.
  - Else stay, cnt=0.
- PEND_HI:
  - s=1 and cnt==STABLE_CYCLES-1 → STABLE_HI, dout=1, chg=1, cnt=0.
  - s=1 otherwise → cnt+1.
  - s=0 → STABLE_LO, cnt=0, glitch_cnt+1.
- STABLE_HI / PEND_LO: mirror of the above with levels inverted.
- dout changes only on a STABLE_CYCLES-th consecutive sample of the new value. It never changes in STABLE_* states.
- chg: registered; high exactly one cycle, coincident with the edge at which dout updates; 0 otherwise.
- Latency: din changes between edge 0 and edge 1 and is held → dout and chg update at edge SYNC_STAGES+STABLE_CYCLES (10 with defaults).
- Pulse rejection: a synchronized excursion shorter than STABLE_CYCLES samples returns to STABLE_old, increments glitch_cnt once, and leaves dout unchanged. An excursion of exactly STABLE_CYCLES samples is accepted.
- glitch_cnt:
  - Saturates at 2^GLITCH_W-1 with no wrap.
  - glitch_clr=1 → 0 at the next edge.
  - glitch_clr and a glitch in the same cycle → clear wins (result 0).
  - glitch_clr has no effect on FSM, dout or chg.
- Bounce handling: each revert resets the count. A fresh transition restarts counting from 1 in the following cycle via the STABLE_* state.
- dout is a flop output with no combinational path from din.

Test Plan:
- Reset/idle: rst high 3 cycles, release, din=1 for 20 cycles → dout=1, chg=0, glitch_cnt=0 throughout.
- Clean fall (defaults): din 1→0 just after edge 0, held → dout=0 and chg=1 at edge 10 only; chg=0 at edges 9 and 11.
- Glitch rejection: from dout=1, din=0 for 7 cycles then back to 1 → dout stays 1, no chg, glitch_cnt=1. Repeat with an 8-cycle low → dout=0 and chg pulses, glitch_cnt still 1.
- Bounce then settle: din toggles 0/1/0/1/0 every 2 cycles, then 0 steady → glitch_cnt increments per revert (2 with this pattern), dout=0 exactly 8 samples after the final synchronized fall.
- Saturation/clear:
  - GLITCH_W=2, inject 5 three-cycle glitches → glitch_cnt=3.
  - glitch_clr asserted in the same cycle as a 6th revert → glitch_cnt=0.
- Reset mid-pending: din falls, rst asserted at edge 6, din held low → after release dout=1 for one cycle, chg=0 during reset. The fall is re-detected 10 edges after release (sync refilled from RESET_LEVEL).
